// File: rtl/eight_bit_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package eight_bit_divider_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // 2'b11 is never entered on purpose; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/eight_bit_divider_if.sv
// Request/result bundle between the control FSM (master) and the divider (slave).
// Handshake: START is sampled only while the divider is idle; BUSY is high during the
// iterations; DONE is a one-cycle pulse when QUOT/REM/DIV_ZERO hold a new result.
interface eight_bit_divider_if
  import eight_bit_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] QUOT;
  logic [WIDTH-1:0] REM;
  logic             DIV_ZERO;

  modport master (output START, A, B, input BUSY, DONE, QUOT, REM, DIV_ZERO);
  modport slave  (input START, A, B, output BUSY, DONE, QUOT, REM, DIV_ZERO);
endinterface

// File: rtl/div_trial_sub.sv
// Ripple subtractor a - b: full adders fed with inverted b and a carry-in of 1.
// A final carry-out of 1 means the subtraction did not borrow.
module div_trial_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);
  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign no_borrow = carry[W];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the primitive the team's ripple-carry adders are built from.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/eight_bit_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, START/BUSY/DONE handshake.
module eight_bit_divider
  import eight_bit_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  eight_bit_divider_if.slave  bus,
  output state_t              state
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, v_q, q_q;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             div_zero_q;

  logic [WIDTH:0]   rs, t, r_next;
  logic             no_borrow;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // The trial is WIDTH+1 bits wide because the shifted remainder can reach 2V-1.
  assign rs = {r_q[WIDTH-1:0], d_q[WIDTH-1]};

  div_trial_sub #(.W(WIDTH + 1)) u_trial (
    .a         (rs),
    .b         ({1'b0, v_q}),
    .diff      (t),
    .no_borrow (no_borrow)
  );

  assign r_next    = no_borrow ? t : rs;
  assign q_next    = {q_q[WIDTH-2:0], no_borrow};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = (bus.B == '0) ? FIN : RUN;
      RUN:     if (last_iter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_q        <= '0;
      v_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            if (bus.B != '0) begin
              d_q   <= bus.A;
              v_q   <= bus.B;
              r_q   <= '0;
              q_q   <= '0;
              cnt_q <= '0;
            end else begin
              quot_q     <= '1;
              rem_q      <= bus.A;
              div_zero_q <= 1'b1;
            end
          end
        end
        RUN: begin
          d_q   <= {d_q[WIDTH-2:0], 1'b0};
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            quot_q     <= q_next;
            rem_q      <= r_next[WIDTH-1:0];
            div_zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // R < V after every iteration, so the top remainder bit and the shifted-out Q bit carry nothing.
  logic unused;
  assign unused = ^{r_q[WIDTH], q_q[WIDTH-1]};

  assign bus.BUSY     = (state_q == RUN);
  assign bus.DONE     = (state_q == FIN);
  assign bus.QUOT     = quot_q;
  assign bus.REM      = rem_q;
  assign bus.DIV_ZERO = div_zero_q;
  assign state        = state_q;
endmodule

// File: tb/tb_eight_bit_divider.sv
// Bench for eight_bit_divider: directed boundary cases plus random operands checked
// every cycle against a timing/arithmetic model built from plain division.
module tb_eight_bit_divider;
  import eight_bit_divider_pkg::*;

  localparam int W  = 8;
  localparam int SW = 2 * W + 1;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   chk_en = 1'b0;
  state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  eight_bit_divider_if #(.WIDTH(W)) bus ();

  eight_bit_divider #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST   (rst),
    .bus   (bus),
    .state (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [SW-1:0] exp_q[$];
  int            m_busy_left = 0;
  logic          m_done = 1'b0;
  logic [W-1:0]  m_quot = '0, m_rem = '0, p_quot = '0, p_rem = '0;
  logic          m_dz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy_left = 0;
      m_done      = 1'b0;
      m_quot      = '0;
      m_rem       = '0;
      m_dz        = 1'b0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_done = 1'b1;
        m_quot = p_quot;
        m_rem  = p_rem;
        m_dz   = 1'b0;
      end
    end else if (bus.START) begin
      if (bus.B == 0) begin
        m_done = 1'b1;
        m_quot = '1;
        m_rem  = bus.A;
        m_dz   = 1'b1;
        exp_q.push_back({1'b1, {W{1'b1}}, bus.A});
      end else begin
        p_quot      = bus.A / bus.B;
        p_rem       = bus.A % bus.B;
        m_busy_left = W;
        exp_q.push_back({1'b0, p_quot, p_rem});
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [SW-1:0] e;
    if (chk_en) begin
      n_checks++;
      if ({bus.BUSY, bus.DONE, bus.QUOT, bus.REM, bus.DIV_ZERO} !==
          {(m_busy_left > 0), m_done, m_quot, m_rem, m_dz}) begin
        n_errors++;
        $display("FAIL cycle @%0t: got busy=%b done=%b q=%0d r=%0d dz=%b, want busy=%b done=%b q=%0d r=%0d dz=%b",
                 $time, bus.BUSY, bus.DONE, bus.QUOT, bus.REM, bus.DIV_ZERO,
                 (m_busy_left > 0), m_done, m_quot, m_rem, m_dz);
      end
      if (bus.DONE === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL scoreboard @%0t: DONE with no pending request", $time);
        end else begin
          e = exp_q.pop_front();
          if ({bus.DIV_ZERO, bus.QUOT, bus.REM} !== e) begin
            n_errors++;
            $display("FAIL scoreboard @%0t: got dz=%b q=%0d r=%0d, want dz=%b q=%0d r=%0d",
                     $time, bus.DIV_ZERO, bus.QUOT, bus.REM, e[SW-1], e[SW-2:W], e[W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one request, scramble operands afterwards, wait for DONE (bounded).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.START = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
      end
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.DONE === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no DONE for a=%0d b=%0d", a, b);
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0},
    '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0},
    '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0},
    '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0},
    '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0},
    '{8'd13,  8'd0,   8'd255, 8'd13, 1'b1}
  };

  initial begin
    int lat, busy_n, last_done, dones;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // reset
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_val("reset_state", int'(state_dbg), int'(IDLE));
    check_val("reset_quot", bus.QUOT, 0);
    check_val("reset_rem", bus.REM, 0);
    check_val("reset_busy_done", {bus.BUSY, bus.DONE, bus.DIV_ZERO}, 0);
    rst = 1'b0;

    // directed boundaries with hand-computed results
    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, lat, busy_n);
      check_val($sformatf("quot_%0d_%0d", vecs[k].a, vecs[k].b), bus.QUOT, vecs[k].q);
      check_val($sformatf("rem_%0d_%0d", vecs[k].a, vecs[k].b), bus.REM, vecs[k].r);
      check_val($sformatf("dz_%0d_%0d", vecs[k].a, vecs[k].b), bus.DIV_ZERO, vecs[k].dz);
      check_val($sformatf("latency_%0d_%0d", vecs[k].a, vecs[k].b), lat, vecs[k].dz ? 1 : W + 1);
      check_val($sformatf("busy_cycles_%0d_%0d", vecs[k].a, vecs[k].b), busy_n, vecs[k].dz ? 0 : W);
      if (k == 0) begin
        repeat (3) @(negedge clk);
        check_val("hold_quot", bus.QUOT, 28);
        check_val("hold_rem", bus.REM, 4);
      end
    end

    // START held high with operands changing every cycle
    @(negedge clk);
    bus.START = 1'b1;
    last_done = -1;
    dones     = 0;
    for (int i = 0; i < 45; i++) begin
      bus.A = (i % 2 == 0) ? 8'd200 : 8'd100;
      bus.B = (i % 2 == 0) ? 8'd7 : 8'd10;
      @(negedge clk);
      if (bus.DONE === 1'b1) begin
        if (last_done >= 0) check_val("held_start_interval", i - last_done, W + 2);
        last_done = i;
        dones++;
      end
    end
    bus.START = 1'b0;
    check_val("held_start_dones", dones, 4);
    repeat (12) @(negedge clk);

    // reset in the 4th RUN cycle abandons the operation
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = 8'd50;
    bus.B     = 8'd3;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrun_reset_outputs", {bus.BUSY, bus.DONE, bus.QUOT, bus.REM}, 0);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) dones++;
    end
    check_val("abandoned_no_done", dones, 0);
    run_op(8'd100, 8'd10, lat, busy_n);
    check_val("after_reset_quot", bus.QUOT, 10);
    check_val("after_reset_rem", bus.REM, 0);

    // random sweep, some divide-by-zero, random idle gaps
    for (int n = 0; n < 2500; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
      run_op(ra, rb, lat, busy_n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
